// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants and state encoding for the stopwatch controller.
package stopwatch_ctrl_pkg;

  // FSM state encoding, also shown on the state LEDs
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FULL  = 3'd4
  } swState_e;

  // 10 ms debounce window and 100 Hz count rate at a 50 MHz clock
  localparam int unsigned DEB_CYCLES_DEF = 500000;
  localparam int unsigned TICK_DIV_DEF   = 500000;

  // The prescaler only advances while the stopwatch is counting
  function automatic logic isCounting(swState_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push button: 2-flop synchronizer, level debouncer and press-edge detector.
// Keys are active-low; a press pulse fires once when the debounced level falls.
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          levelDly_q;
  logic [CW-1:0] debCnt_q;
  logic [CW-1:0] debCnt_d;

  // Bring the raw key into the clock domain; idle level is released (1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples
  always_comb begin
    level_d  = level_q;
    debCnt_d = debCnt_q;
    if (sync2_q == level_q) begin
      debCnt_d = '0;
    end else if (debCnt_q == CNT_LAST) begin
      level_d  = sync2_q;
      debCnt_d = '0;
    end else begin
      debCnt_d = debCnt_q + 1'b1;
    end
  end

  // Debounced level, its one-cycle delayed copy and the run counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q    <= 1'b1;
      levelDly_q <= 1'b1;
      debCnt_q   <= '0;
    end else begin
      level_q    <= level_d;
      levelDly_q <= level_q;
      debCnt_q   <= debCnt_d;
    end
  end

  // Press is the 1->0 transition of the debounced level; release is ignored
  assign press_o = levelDly_q & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: two debounced keys, 100 Hz prescaler and the mode FSM
// driving a downstream BCD counter chain and display latch.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_ss,
  input  logic       key_lc,
  input  logic       cnt_max,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic       disp_hold,
  output logic [2:0] state_out
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          ssPress;
  logic          lcPress;
  logic          lcEff;
  logic          terminal;
  swState_e      state_q;
  swState_e      state_d;
  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic          cntEnable_q;
  logic          cntEnable_d;
  logic          cntClear_q;
  logic          cntClear_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) uKeySs (
    .clk     (clk),
    .reset   (reset),
    .key_i   (key_ss),
    .press_o (ssPress)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) uKeyLc (
    .clk     (clk),
    .reset   (reset),
    .key_i   (key_lc),
    .press_o (lcPress)
  );

  // A start/stop press in the same cycle swallows the lap/clear press
  assign lcEff    = lcPress & ~ssPress;
  assign terminal = isCounting(state_q) && (tick_q == TICK_LAST);

  // Next state, counter pulses and prescaler advance
  always_comb begin
    state_d     = state_q;
    cntEnable_d = 1'b0;
    cntClear_d  = 1'b0;
    tick_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (ssPress) state_d = ST_RUN;
      end
      ST_RUN, ST_LAP: begin
        if (ssPress) begin
          state_d = ST_PAUSE;
        end else if (terminal && cnt_max) begin
          state_d = ST_FULL;
        end else begin
          cntEnable_d = terminal;
          if (lcEff) state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ssPress) begin
          state_d = ST_RUN;
        end else if (lcEff) begin
          state_d    = ST_IDLE;
          cntClear_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (lcEff) begin
          state_d    = ST_IDLE;
          cntClear_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (isCounting(state_q) && isCounting(state_d)) begin
      tick_d = terminal ? '0 : tick_q + 1'b1;
    end
  end

  // State, prescaler and registered counter-chain pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      cntEnable_q <= 1'b0;
      cntClear_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      cntEnable_q <= cntEnable_d;
      cntClear_q  <= cntClear_d;
    end
  end

  assign cnt_enable = cntEnable_q;
  assign cnt_clear  = cntClear_q;
  assign disp_hold  = (state_q == ST_LAP);
  assign state_out  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 10;
  localparam int IDLE = 0, RUN = 1, LAP = 2, PAUSE = 3, FULL = 4;

  logic       clk;
  logic       reset;
  logic       key_ss;
  logic       key_lc;
  logic       cnt_max;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       disp_hold;
  logic [2:0] state_out;

  int nCompared   = 0;
  int nMismatched = 0;
  int enCount     = 0;
  int clrCount    = 0;

  // reference model state: raw-key delay line, sample history, levels, mode
  bit pipe[2][2];
  bit smp[2][DEB];
  int nSmp[2];
  bit mLvl[2];
  bit mPress[2];
  int mState;
  int mPhase;
  bit mEn;
  bit mClr;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_ss     (key_ss),
    .key_lc     (key_lc),
    .cnt_max    (cnt_max),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .disp_hold  (disp_hold),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] = 1'b1;
      pipe[k][1] = 1'b1;
      nSmp[k]    = 0;
      mLvl[k]    = 1'b1;
      mPress[k]  = 1'b0;
    end
    mState = IDLE;
    mPhase = 0;
    mEn    = 1'b0;
    mClr   = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  function automatic void modelEdge();
    bit raw[2];
    bit ssP, lcE, active, nextActive, term, allDiff, sample;
    int nxt;
    raw[0] = key_ss;
    raw[1] = key_lc;
    ssP    = mPress[0];
    lcE    = mPress[1] && !mPress[0];
    active = (mState == RUN) || (mState == LAP);
    term   = active && (mPhase == TDIV - 1);
    nxt    = mState;
    mEn    = 1'b0;
    mClr   = 1'b0;
    case (mState)
      IDLE: if (ssP) nxt = RUN;
      RUN, LAP: begin
        if (ssP) nxt = PAUSE;
        else if (term && cnt_max) nxt = FULL;
        else begin
          mEn = term;
          if (lcE) nxt = (mState == RUN) ? LAP : RUN;
        end
      end
      PAUSE: begin
        if (ssP) nxt = RUN;
        else if (lcE) begin nxt = IDLE; mClr = 1'b1; end
      end
      FULL: if (lcE) begin nxt = IDLE; mClr = 1'b1; end
      default: nxt = IDLE;
    endcase
    nextActive = (nxt == RUN) || (nxt == LAP);
    mPhase = (active && nextActive) ? (term ? 0 : mPhase + 1) : 0;
    mState = nxt;
    for (int k = 0; k < 2; k++) begin
      sample     = pipe[k][0];
      pipe[k][0] = pipe[k][1];
      pipe[k][1] = raw[k];
      for (int i = DEB - 1; i > 0; i--) smp[k][i] = smp[k][i-1];
      smp[k][0] = sample;
      if (nSmp[k] < DEB) nSmp[k]++;
      allDiff = (nSmp[k] == DEB);
      for (int i = 0; i < DEB; i++) if (smp[k][i] == mLvl[k]) allDiff = 1'b0;
      mPress[k] = 1'b0;
      if (allDiff) begin
        mPress[k] = mLvl[k];
        mLvl[k]   = !mLvl[k];
      end
    end
  endfunction

  task automatic checkOutput(string tag);
    nCompared++;
    assert (state_out === 3'(mState)) else begin
      nMismatched++;
      $error("[TB] FAIL %s state_out got=%0d exp=%0d", tag, state_out, mState);
    end
    nCompared++;
    assert (cnt_enable === mEn) else begin
      nMismatched++;
      $error("[TB] FAIL %s cnt_enable got=%b exp=%b", tag, cnt_enable, mEn);
    end
    nCompared++;
    assert (cnt_clear === mClr) else begin
      nMismatched++;
      $error("[TB] FAIL %s cnt_clear got=%b exp=%b", tag, cnt_clear, mClr);
    end
    nCompared++;
    assert (disp_hold === (mState == LAP)) else begin
      nMismatched++;
      $error("[TB] FAIL %s disp_hold got=%b exp=%b", tag, disp_hold, (mState == LAP));
    end
  endtask

  task automatic checkVal(string tag, int got, int exp);
    nCompared++;
    assert (got === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(bit ss, bit lc, bit mx);
    key_ss  = ss;
    key_lc  = lc;
    cnt_max = mx;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
    if (cnt_enable === 1'b1) enCount++;
    if (cnt_clear === 1'b1) clrCount++;
  endtask

  // Hold the selected keys low for len cycles, then release and let them settle
  task automatic pressKey(bit ss, bit lc, int len, string tag);
    applyStimulus(!ss, !lc, cnt_max);
    repeat (len) step(tag);
    applyStimulus(1'b1, 1'b1, cnt_max);
    repeat (DEB + 4) step(tag);
  endtask

  initial begin
    int n;
    int segLen;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    modelReset();
    #12;
    checkOutput("resetState");
    @(negedge clk);
    reset = 1'b1;

    // start: press latency and prescaler period
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (state_out !== 3'd1 && n < 20) begin step("ssStart"); n++; end
    checkVal("ssLatency", n, DEB + 3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    n = 0;
    do begin step("firstEnable"); n++; end while (cnt_enable !== 1'b1 && n < 30);
    checkVal("firstEnableGap", n, TDIV);
    n = 0;
    do begin step("nextEnable"); n++; end while (cnt_enable !== 1'b1 && n < 30);
    checkVal("nextEnableGap", n, TDIV);

    // glitch rejection, then a genuine 4-cycle press
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) step("glitch");
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (10) step("glitch");
    checkVal("glitchState", int'(state_out), RUN);
    pressKey(1'b1, 1'b0, 4, "ssPause");
    checkVal("pausedOnce", int'(state_out), PAUSE);

    // lap view keeps counting
    pressKey(1'b1, 1'b0, 4, "resume");
    pressKey(1'b0, 1'b1, 4, "lapIn");
    checkVal("lapState", int'(state_out), LAP);
    checkVal("lapHold", int'(disp_hold), 1);
    enCount = 0;
    repeat (TDIV + 2) step("lapCount");
    checkVal("lapCounting", int'(enCount > 0), 1);
    pressKey(1'b0, 1'b1, 4, "lapOut");
    checkVal("lapOutState", int'(state_out), RUN);
    checkVal("lapOutHold", int'(disp_hold), 0);

    // pause stops counting, clear returns to idle with one pulse
    pressKey(1'b1, 1'b0, 4, "pause");
    enCount = 0;
    repeat (2 * TDIV) step("pauseQuiet");
    checkVal("pauseNoEnable", enCount, 0);
    clrCount = 0;
    pressKey(1'b0, 1'b1, 4, "clear");
    checkVal("clearState", int'(state_out), IDLE);
    checkVal("clearPulses", clrCount, 1);

    // counter chain full
    pressKey(1'b1, 1'b0, 4, "runFull");
    applyStimulus(1'b1, 1'b1, 1'b1);
    enCount = 0;
    n = 0;
    while (state_out !== 3'd4 && n < 30) begin step("toFull"); n++; end
    checkVal("fullState", int'(state_out), FULL);
    checkVal("fullNoEnable", enCount, 0);
    pressKey(1'b1, 1'b0, 4, "fullSs");
    checkVal("fullSsIgnored", int'(state_out), FULL);
    clrCount = 0;
    pressKey(1'b0, 1'b1, 4, "fullClear");
    checkVal("fullClearState", int'(state_out), IDLE);
    checkVal("fullClearPulses", clrCount, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);

    // simultaneous presses act as start/stop only
    pressKey(1'b1, 1'b0, 4, "runBoth");
    pressKey(1'b1, 1'b1, 4, "both");
    checkVal("bothState", int'(state_out), PAUSE);

    // asynchronous reset in the middle of lap view
    pressKey(1'b1, 1'b0, 4, "runReset");
    pressKey(1'b0, 1'b1, 4, "lapReset");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("resetMidLap");
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // key already held low when reset releases
    n = 0;
    while (state_out !== 3'd1 && n < 20) begin step("heldKey"); n++; end
    checkVal("heldKeyLatency", n, DEB + 3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (DEB + 4) step("heldRelease");

    // randomized key and cnt_max activity against the model
    for (int seg = 0; seg < 400; seg++) begin
      segLen = $urandom_range(1, 7);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0));
      repeat (segLen) step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
